// File: rtl/ysyx_22050058_ifetch_resp.sv
// Instruction-fetch line buffer: one line of LINE_WORDS instructions, refilled word by word on a miss.
// Latency: hits return in the same cycle; a zero-wait refill stalls fetch for 2*LINE_WORDS+1 cycles.
// Backpressure: holds the request valid/address while mem_req_ready_i is low and waits in RESP for data.
//
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   if_ce_i, if_pc_i         fetch enable and fetch address from the PC register
//   if_inst_o                instruction to IF-ID (NOP while stalling, 0 when fetch is disabled)
//   if_stall_req_o           stall request to the control block
//   flush_i                  invalidate the line buffer
//   mem_req_valid_o/addr_o   registered word-read request, held until mem_req_ready_i
//   mem_resp_valid_i/data_i  read response, one word per accepted request
module ysyx_22050058_ifetch_resp #(
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [63:0] if_pc_i,
   output logic [31:0] if_inst_o,
   output logic        if_stall_req_o,
   input  logic        flush_i,
   output logic        mem_req_valid_o,
   output logic [63:0] mem_req_addr_o,
   input  logic        mem_req_ready_i,
   input  logic        mem_resp_valid_i,
   input  logic [31:0] mem_resp_data_i
);

   localparam int KW  = $clog2(LINE_WORDS);
   localparam int OFS = KW + 2;
   localparam int TW  = 64 - OFS;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic            line_valid;
   logic [TW-1:0]   line_tag;
   logic [TW-1:0]   rtag;
   logic [31:0]     data [LINE_WORDS];
   logic [KW-1:0]   k;
   logic [KW-1:0]   k_nxt;
   logic            discard;
   logic [TW-1:0]   pc_tag;
   logic [KW-1:0]   pc_idx;
   logic            hit;
   logic            miss;
   logic            last_word;
   logic            unused_pc_bits;

   assign pc_tag         = if_pc_i[63:OFS];
   assign pc_idx         = if_pc_i[OFS-1:2];
   assign k_nxt          = k + KW'(1);
   assign last_word      = (k == KW'(LINE_WORDS - 1));
   // Instruction addresses are word aligned; the byte offset carries no information.
   assign unused_pc_bits = ^if_pc_i[1:0];

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (miss) state_nxt = REQ;
         REQ:     if (mem_req_ready_i) state_nxt = RESP;
         RESP:    if (mem_resp_valid_i) state_nxt = last_word ? IDLE : REQ;
         default: state_nxt = IDLE;
      endcase
   end

   // Fetch-side outputs. Hits are only served from IDLE so a line being
   // rewritten (or a stale tag during refill) can never be returned.
   always_comb begin
      hit            = if_ce_i && line_valid && (line_tag == pc_tag) && (state == IDLE);
      miss           = if_ce_i && !hit;
      if_stall_req_o = miss;
      if_inst_o      = 32'h0;
      if (hit) begin
         if_inst_o = data[pc_idx];
      end else if (if_ce_i) begin
         if_inst_o = NOP;
      end
   end

   // Line bookkeeping and registered memory request
   always_ff @(posedge clk) begin
      if (!rst) begin
         line_valid      <= 1'b0;
         line_tag        <= '0;
         rtag            <= '0;
         k               <= '0;
         discard         <= 1'b0;
         mem_req_valid_o <= 1'b0;
         mem_req_addr_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_i) line_valid <= 1'b0;
               if (miss) begin
                  // Invalidate up front: the array is overwritten word by word.
                  line_valid      <= 1'b0;
                  rtag            <= pc_tag;
                  k               <= '0;
                  discard         <= 1'b0;
                  mem_req_valid_o <= 1'b1;
                  mem_req_addr_o  <= {pc_tag, {KW{1'b0}}, 2'b00};
               end
            end
            REQ: begin
               if (flush_i) discard <= 1'b1;
               if (mem_req_ready_i) mem_req_valid_o <= 1'b0;
            end
            RESP: begin
               if (flush_i) discard <= 1'b1;
               if (mem_resp_valid_i) begin
                  if (last_word) begin
                     line_tag   <= rtag;
                     // A flush arriving with the final word must still win.
                     line_valid <= !(discard || flush_i);
                  end else begin
                     k               <= k_nxt;
                     mem_req_valid_o <= 1'b1;
                     mem_req_addr_o  <= {rtag, k_nxt, 2'b00};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Instruction storage (no reset needed; guarded by line_valid)
   always_ff @(posedge clk) begin
      if (rst && (state == RESP) && mem_resp_valid_i) begin
         data[k] <= mem_resp_data_i;
      end
   end

endmodule

// File: tb/tb_ysyx_22050058_ifetch_resp.sv
module tb_ysyx_22050058_ifetch_resp;

   localparam int N = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_ce_i;
   logic [63:0] if_pc_i;
   logic [31:0] if_inst_o;
   logic        if_stall_req_o;
   logic        flush_i;
   logic        mem_req_valid_o;
   logic [63:0] mem_req_addr_o;
   logic        mem_req_ready_i;
   logic        mem_resp_valid_i;
   logic [31:0] mem_resp_data_i;

   always #5 clk = ~clk;

   ysyx_22050058_ifetch_resp #(.LINE_WORDS(N)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_ce_i          (if_ce_i),
      .if_pc_i          (if_pc_i),
      .if_inst_o        (if_inst_o),
      .if_stall_req_o   (if_stall_req_o),
      .flush_i          (flush_i),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_resp_data_i  (mem_resp_data_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a one-line cache described by its line base address,
   // plus counts of requests accepted and words returned during a refill.
   logic        m_valid;
   logic [63:0] m_base;
   logic [31:0] m_data [N];
   bit          m_busy;
   bit          m_disc;
   logic [63:0] m_rbase;
   int          m_req;
   int          m_ret;
   int          m_handshakes;
   logic        last_stall;

   function automatic logic [63:0] base_of(input logic [63:0] pc);
      return pc & ~(64'(N * 4) - 64'd1);
   endfunction

   function automatic logic [31:0] memfn(input logic [63:0] a);
      return (a[33:2] * 32'h9E37_79B1) + 32'h0123_4567;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_base  = 64'h0;
      m_busy  = 1'b0;
      m_disc  = 1'b0;
      m_req   = 0;
      m_ret   = 0;
   endtask

   task automatic drive(input logic ce, input logic [63:0] pc, input logic fl,
                        input logic rdy, input logic rv, input logic [31:0] rd);
      if_ce_i          = ce;
      if_pc_i          = pc;
      flush_i          = fl;
      mem_req_ready_i  = rdy;
      mem_resp_valid_i = rv;
      mem_resp_data_i  = rd;
   endtask

   // One clock cycle checked against the model; entered and left at posedge+1.
   task automatic mcyc(input logic ce, input logic [63:0] pc, input logic fl,
                       input logic rdy, input logic rv, input logic [31:0] rd);
      logic        hit;
      logic [31:0] e_inst;
      logic        e_vld;
      int          idx;
      drive(ce, pc, fl, rdy, rv, rd);
      idx    = int'((pc >> 2) & 64'(N - 1));
      hit    = ce && !m_busy && m_valid && (base_of(pc) == m_base);
      e_inst = !ce ? 32'h0 : (hit ? m_data[idx] : NOP);
      e_vld  = m_busy && (m_req == m_ret);
      @(negedge clk);
      last_stall = if_stall_req_o;
      chk("inst", 64'(if_inst_o), 64'(e_inst));
      chk("stall", 64'(if_stall_req_o), 64'(ce && !hit));
      chk("req_vld", 64'(mem_req_valid_o), 64'(e_vld));
      if (e_vld) chk("req_addr", mem_req_addr_o, m_rbase + 64'(4 * m_req));
      if (!m_busy) begin
         if (fl) m_valid = 1'b0;
         if (ce && !hit) begin
            m_busy  = 1'b1;
            m_valid = 1'b0;
            m_rbase = base_of(pc);
            m_req   = 0;
            m_ret   = 0;
            m_disc  = 1'b0;
         end
      end else begin
         if (fl) m_disc = 1'b1;
         if (m_req == m_ret) begin
            if (rdy) begin
               m_req++;
               m_handshakes++;
            end
         end else if (rv) begin
            m_data[m_ret] = rd;
            m_ret++;
            if (m_ret == N) begin
               m_busy  = 1'b0;
               m_valid = !m_disc;
               m_base  = m_rbase;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Fetch pc until it hits; memory delays ready on one word and the response
   // on another, and may flush once while waiting for a given word.
   task automatic refill(input logic [63:0] pc, input int rw_word, input int rw_n,
                         input int vw_word, input int vw_n, input int fl_word,
                         output int stalls);
      int wr;
      int wv;
      bit fl_done;
      bit done;
      wr = 0; wv = 0; fl_done = 1'b0; done = 1'b0; stalls = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         logic        rdy;
         logic        rv;
         logic        fl;
         logic [31:0] rd;
         rdy = 1'b1; rv = 1'b0; fl = 1'b0; rd = 32'h0;
         if (m_busy && m_req == m_ret && m_req == rw_word && wr < rw_n) begin
            rdy = 1'b0;
            wr++;
         end
         if (m_busy && m_req > m_ret) begin
            rd = memfn(m_rbase + 64'(4 * m_ret));
            if (m_ret == vw_word && wv < vw_n) wv++;
            else rv = 1'b1;
            if (m_ret == fl_word && !fl_done) begin
               fl = 1'b1;
               fl_done = 1'b1;
            end
         end
         mcyc(1'b1, pc, fl, rdy, rv, rd);
         if (last_stall) stalls++;
         else done = 1'b1;
      end
      if (!done) chk("refill_timeout", 64'd0, 64'd1);
   endtask

   typedef struct {
      logic        ce;
      logic [63:0] pc;
      logic        rv;
      logic [31:0] rd;
      logic [31:0] inst;
      logic        stall;
      logic        vld;
      logic [63:0] addr;
   } vec_t;

   function automatic vec_t mk(input logic ce, input logic [63:0] pc, input logic rv,
                               input logic [31:0] rd, input logic [31:0] inst,
                               input logic stall, input logic vld, input logic [63:0] addr);
      vec_t v;
      v.ce = ce; v.pc = pc; v.rv = rv; v.rd = rd;
      v.inst = inst; v.stall = stall; v.vld = vld; v.addr = addr;
      return v;
   endfunction

   initial begin
      vec_t        tbl [14];
      int          sc;
      int          hs0;
      logic [63:0] lines [3];
      logic [63:0] pc;

      // Cold miss at 0x80000000 with zero-wait memory, then hits on the line.
      tbl[0]  = mk(1'b1, 64'h8000_0000, 1'b0, 32'h0,  NOP,   1'b1, 1'b0, 64'h0);
      tbl[1]  = mk(1'b1, 64'h8000_0000, 1'b0, 32'h0,  NOP,   1'b1, 1'b1, 64'h8000_0000);
      tbl[2]  = mk(1'b1, 64'h8000_0000, 1'b1, 32'h11, NOP,   1'b1, 1'b0, 64'h0);
      tbl[3]  = mk(1'b1, 64'h8000_0000, 1'b0, 32'h0,  NOP,   1'b1, 1'b1, 64'h8000_0004);
      tbl[4]  = mk(1'b1, 64'h8000_0000, 1'b1, 32'h22, NOP,   1'b1, 1'b0, 64'h0);
      tbl[5]  = mk(1'b1, 64'h8000_0000, 1'b0, 32'h0,  NOP,   1'b1, 1'b1, 64'h8000_0008);
      tbl[6]  = mk(1'b1, 64'h8000_0000, 1'b1, 32'h33, NOP,   1'b1, 1'b0, 64'h0);
      tbl[7]  = mk(1'b1, 64'h8000_0000, 1'b0, 32'h0,  NOP,   1'b1, 1'b1, 64'h8000_000C);
      tbl[8]  = mk(1'b1, 64'h8000_0000, 1'b1, 32'h44, NOP,   1'b1, 1'b0, 64'h0);
      tbl[9]  = mk(1'b1, 64'h8000_0000, 1'b0, 32'h0,  32'h11, 1'b0, 1'b0, 64'h0);
      tbl[10] = mk(1'b1, 64'h8000_0004, 1'b0, 32'h0,  32'h22, 1'b0, 1'b0, 64'h0);
      tbl[11] = mk(1'b1, 64'h8000_0008, 1'b0, 32'h0,  32'h33, 1'b0, 1'b0, 64'h0);
      tbl[12] = mk(1'b1, 64'h8000_000C, 1'b0, 32'h0,  32'h44, 1'b0, 1'b0, 64'h0);
      tbl[13] = mk(1'b0, 64'h0,         1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 64'h0);

      rst = 1'b0;
      drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      model_reset();
      m_handshakes = 0;
      last_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req_vld", 64'(mem_req_valid_o), 64'd0);
      chk("rst_req_addr", mem_req_addr_o, 64'd0);
      chk("rst_inst", 64'(if_inst_o), 64'd0);
      chk("rst_stall", 64'(if_stall_req_o), 64'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].ce, tbl[i].pc, 1'b0, 1'b1, tbl[i].rv, tbl[i].rd);
         @(negedge clk);
         chk($sformatf("vec%0d_inst", i), 64'(if_inst_o), 64'(tbl[i].inst));
         chk($sformatf("vec%0d_stall", i), 64'(if_stall_req_o), 64'(tbl[i].stall));
         chk($sformatf("vec%0d_vld", i), 64'(mem_req_valid_o), 64'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("vec%0d_addr", i), mem_req_addr_o, tbl[i].addr);
         @(posedge clk);
         #1;
      end

      // Model now holds what the table loaded.
      m_valid = 1'b1;
      m_base  = 64'h8000_0000;
      m_data[0] = 32'h11; m_data[1] = 32'h22; m_data[2] = 32'h33; m_data[3] = 32'h44;

      // Crossing into the next line replaces the old one.
      refill(64'h8000_0010, -1, 0, -1, 0, -1, sc);
      chk("cross_stall_cycles", 64'(sc), 64'd9);
      for (int w = 1; w < N; w++) mcyc(1'b1, 64'h8000_0010 + 64'(4 * w), 1'b0, 1'b1, 1'b0, 32'h0);
      refill(64'h8000_0000, -1, 0, -1, 0, -1, sc);
      chk("return_stall_cycles", 64'(sc), 64'd9);

      // Backpressure: ready low 3 cycles on word 1, response 2 cycles late on word 2.
      refill(64'h8000_0020, 1, 3, 2, 2, -1, sc);
      chk("bp_stall_cycles", 64'(sc), 64'd14);
      for (int w = 0; w < N; w++) mcyc(1'b1, 64'h8000_0020 + 64'(4 * w), 1'b0, 1'b1, 1'b0, 32'h0);

      // Flush while waiting for word 2: the refill finishes, then a fresh one runs.
      hs0 = m_handshakes;
      refill(64'h8000_0040, -1, 0, -1, 0, 2, sc);
      chk("flush_stall_cycles", 64'(sc), 64'd18);
      chk("flush_handshakes", 64'(m_handshakes - hs0), 64'd8);

      // Reset while a request is pending.
      refill(64'h8000_0080, -1, 0, -1, 0, -1, sc);
      mcyc(1'b1, 64'h8000_00C0, 1'b0, 1'b0, 1'b0, 32'h0);
      mcyc(1'b1, 64'h8000_00C0, 1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      if_ce_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("midrst_req_vld", 64'(mem_req_valid_o), 64'd0);
      chk("midrst_stall", 64'(if_stall_req_o), 64'd0);
      @(posedge clk);
      #1;
      mcyc(1'b0, 64'h8000_0080, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      mcyc(1'b0, 64'h8000_0080, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
      mcyc(1'b1, 64'h8000_0080, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("midrst_refetch_miss", 64'(last_stall), 64'd1);
      refill(64'h8000_0080, -1, 0, -1, 0, -1, sc);
      chk("midrst_refill_stalls", 64'(sc), 64'd8);

      // Randomized traffic against the model.
      lines[0] = 64'h8000_0000;
      lines[1] = 64'h8000_0010;
      lines[2] = 64'h8000_1000;
      pc = lines[0];
      for (int c = 0; c < 3000; c++) begin
         logic        ce;
         logic        fl;
         logic        rdy;
         logic        rv;
         logic [31:0] rd;
         if ($urandom_range(0, 99) < 30)
            pc = lines[$urandom_range(0, 2)] + 64'(4 * $urandom_range(0, N - 1));
         ce  = ($urandom_range(0, 99) < 90);
         fl  = ($urandom_range(0, 99) < 3);
         rdy = 1'($urandom_range(0, 1));
         rv  = 1'($urandom_range(0, 1));
         rd  = (m_busy && m_req > m_ret) ? memfn(m_rbase + 64'(4 * m_ret)) : $urandom;
         mcyc(ce, pc, fl, rdy, rv, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
